// File: rtl/sort4_ctrl.sv
// Loads four 4-bit words, bubble-sorts them in place with one shared comparator, then drains them in ascending order.
// Latency: 3 cycles per compare pass (1..3 passes) after the 4th word is accepted; drain is one word per handshake.
// Backpressure: in_ready only in LOAD; out_ready low in DRAIN holds out_data/out_valid stable.
module sort4_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic [2:0] swap_cnt
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_buf [4];
    logic [1:0] r_wr_idx;
    logic [1:0] r_rd_idx;
    logic [1:0] r_j;
    logic [1:0] r_pass;
    logic       r_swapped;
    logic [2:0] r_swap_cnt;

    logic [1:0] w_j1;
    logic [3:0] w_cmp_a;
    logic [3:0] w_cmp_b;
    logic       w_g;
    logic       w_l;
    logic       w_e;
    logic       w_pass_swapped;

    // The single magnitude comparator; every compare step muxes its operands here.
    assign w_j1    = r_j + 2'd1;
    assign w_cmp_a = r_buf[r_j];
    assign w_cmp_b = r_buf[w_j1];
    assign w_g     = (w_cmp_a > w_cmp_b);
    assign w_l     = (w_cmp_a < w_cmp_b);
    assign w_e     = ~(w_g | w_l);

    assign w_pass_swapped = r_swapped | w_g;

    assign in_ready  = (r_state == LOAD);
    assign busy      = (r_state == SORT);
    assign out_valid = (r_state == DRAIN);
    assign out_data  = (r_state == DRAIN) ? r_buf[r_rd_idx] : 4'h0;
    assign swap_cnt  = r_swap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_wr_idx   <= 2'd0;
            r_rd_idx   <= 2'd0;
            r_j        <= 2'd0;
            r_pass     <= 2'd0;
            r_swapped  <= 1'b0;
            r_swap_cnt <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= 4'h0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_buf[r_wr_idx] <= in_data;
                        r_wr_idx        <= r_wr_idx + 2'd1;
                        if (r_wr_idx == 2'd3) begin
                            r_state    <= SORT;
                            r_j        <= 2'd0;
                            r_pass     <= 2'd0;
                            r_swapped  <= 1'b0;
                            r_swap_cnt <= 3'd0;
                        end
                    end
                end
                SORT: begin
                    // Equal or smaller neighbours stay put, keeping the sort stable.
                    if (w_g && !w_e) begin
                        r_buf[r_j]  <= w_cmp_b;
                        r_buf[w_j1] <= w_cmp_a;
                        r_swap_cnt  <= r_swap_cnt + 3'd1;
                        r_swapped   <= 1'b1;
                    end
                    if (r_j == 2'd2) begin
                        if (!w_pass_swapped || r_pass == 2'd2) begin
                            r_state  <= DRAIN;
                            r_rd_idx <= 2'd0;
                        end else begin
                            r_j       <= 2'd0;
                            r_pass    <= r_pass + 2'd1;
                            r_swapped <= 1'b0;
                        end
                    end else begin
                        r_j <= w_j1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        r_rd_idx <= r_rd_idx + 2'd1;
                        if (r_rd_idx == 2'd3) begin
                            r_state  <= LOAD;
                            r_wr_idx <= 2'd0;
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Bench for sort4_ctrl: directed and random loads compared against an inversion-count sorting model.
module tb_sort4_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       busy;
    logic [2:0] swap_cnt;

    int errs;
    int checks;

    sort4_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .swap_cnt  (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 = out_ready always high, 1 = 1-0-0-1 then high, 2 = random
    task automatic run_case(input logic [3:0] w0, input logic [3:0] w1,
                            input logic [3:0] w2, input logic [3:0] w3,
                            input int mode, input bit hold);
        logic [3:0] w [4];
        int         q[$];
        int         inv;
        int         maxd;
        int         cnt;
        int         passes;
        int         nb;
        int         idx;
        int         cyc;
        logic       rdy;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        inv  = 0;
        maxd = 0;
        q    = {};
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            for (int k = 0; k < i; k++) if (w[k] > w[i]) cnt++;
            inv += cnt;
            if (cnt > maxd) maxd = cnt;
            q.push_back(int'(w[i]));
        end
        q.sort();
        passes = (maxd + 1 > 3) ? 3 : maxd + 1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL load_ready word%0d: got %b want 1", i, in_ready);
            end
        end
        @(negedge clk);
        in_valid = hold;
        in_data  = 4'($urandom_range(0, 15));
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            @(negedge clk);
            if (hold) in_data = 4'($urandom_range(0, 15));
        end
        checks++;
        if (nb != 3 * passes) begin
            errs++;
            $display("FAIL busy_cycles: got %0d want %0d", nb, 3 * passes);
        end

        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 64) begin
            if (mode == 1)      rdy = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
            else if (mode == 2) rdy = 1'($urandom_range(0, 1));
            else                rdy = 1'b1;
            out_ready = rdy;
            if (hold) in_data = 4'($urandom_range(0, 15));
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'(q[idx]) || swap_cnt !== 3'(inv)) begin
                errs++;
                $display("FAIL drain word%0d cyc%0d: got v=%b d=%0d sc=%0d want v=1 d=%0d sc=%0d",
                         idx, cyc, out_valid, out_data, swap_cnt, q[idx], inv);
            end
            if (rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (idx != 4) begin
            errs++;
            $display("FAIL drain_timeout: got %0d words want 4", idx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0 ||
            busy !== 1'b0 || swap_cnt !== 3'(inv)) begin
            errs++;
            $display("FAIL post_drain: got rdy=%b v=%b d=%0d busy=%b sc=%0d want 1 0 0 0 %0d",
                     in_ready, out_valid, out_data, busy, swap_cnt, inv);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_data !== 4'h0 || swap_cnt !== 3'd0) begin
            errs++;
            $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b d=%0d sc=%0d want 1 0 0 0 0",
                     in_ready, out_valid, busy, out_data, swap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_case(4'd1, 4'd2, 4'd3, 4'd4, 0, 1'b0);
        run_case(4'd9, 4'd7, 4'd5, 4'd3, 0, 1'b0);
        run_case(4'd5, 4'd5, 4'd2, 4'd5, 0, 1'b0);
        run_case(4'd15, 4'd0, 4'd15, 4'd0, 1, 1'b0);
    endtask

    task automatic test_mid_sort_reset();
        logic [3:0] seq [4];
        seq[0] = 4'd9; seq[1] = 4'd7; seq[2] = 4'd5; seq[3] = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = seq[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_data !== 4'h0 || swap_cnt !== 3'd0) begin
            errs++;
            $display("FAIL async_reset: got rdy=%b v=%b busy=%b d=%0d sc=%0d want 1 0 0 0 0",
                     in_ready, out_valid, busy, out_data, swap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_case(4'd4, 4'd3, 4'd2, 4'd1, 0, 1'b0);
    endtask

    task automatic test_hold_valid();
        run_case(4'd8, 4'd1, 4'd6, 4'd2, 0, 1'b1);
        run_case(4'd3, 4'd12, 4'd0, 4'd7, 2, 1'b1);
        run_case(4'd2, 4'd4, 4'd6, 4'd8, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_case(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     2, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_mid_sort_reset();
        test_hold_valid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
